acc_bank: RTL

ACC_BANK -- requirements
Module: acc_bank

---
 rtl/acc_bank.sv | 134 +++++++++++++
 1 files changed

// File: rtl/acc_bank.sv
// rtl/acc_bank.sv - bank of accumulators with an ALU, shift-add multiplier and result handshake
module acc_bank #(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int SW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [SW-1:0]    op_sel,
    input  logic [WIDTH-1:0] op_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [2:0]       res_flags,
    input  logic [SW-1:0]    rd_sel,
    output logic [WIDTH-1:0] rd_data
);
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_MUL   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_NOT   = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_READ  = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_RESP} state_t;

    state_t             state;
    logic [WIDTH-1:0]   acc [NREGS];
    logic [SW-1:0]      sel_q;
    logic [WIDTH-1:0]   mplr;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;

    logic               accept;
    logic [WIDTH-1:0]   cur;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_wr;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] prod_next;

    assign accept  = op_valid && op_ready;
    assign cur     = acc[op_sel];
    assign sum     = {1'b0, cur} + {1'b0, op_data};
    assign rd_data = acc[rd_sel];

    always_comb begin
        alu_res   = cur;
        alu_carry = 1'b0;
        alu_wr    = 1'b1;
        case (op_code)
            OP_ADD:   begin alu_res = sum[WIDTH-1:0]; alu_carry = sum[WIDTH]; end
            OP_AND:   alu_res = cur & op_data;
            OP_OR:    alu_res = cur | op_data;
            OP_NOT:   alu_res = ~cur;
            OP_LOAD:  alu_res = op_data;
            OP_CLEAR: alu_res = '0;
            default:  alu_wr  = 1'b0;
        endcase
    end

    // One partial product per cycle: multiplicand shifted by the step index.
    assign addend    = mplr[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
    assign prod_next = prod + addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_flags <= '0;
            sel_q     <= '0;
            mplr      <= '0;
            mcand     <= '0;
            prod      <= '0;
            cnt       <= '0;
            for (int i = 0; i < NREGS; i++) acc[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    op_ready <= 1'b1;
                    if (accept) begin
                        op_ready <= 1'b0;
                        sel_q    <= op_sel;
                        mplr     <= op_data;
                        mcand    <= cur;
                        if (op_code == OP_MUL) begin
                            prod  <= '0;
                            cnt   <= '0;
                            state <= S_MUL;
                        end else begin
                            if (alu_wr) acc[op_sel] <= alu_res;
                            res_valid <= 1'b1;
                            res_data  <= alu_res;
                            res_flags <= {alu_carry, 1'b0, alu_res == '0};
                            state     <= S_RESP;
                        end
                    end
                end
                S_MUL: begin
                    prod <= prod_next;
                    mplr <= mplr >> 1;
                    cnt  <= cnt + 1'b1;
                    // Last step folds straight into the write so latency is WIDTH+1.
                    if (cnt == CW'(WIDTH - 1)) begin
                        acc[sel_q] <= prod_next[WIDTH-1:0];
                        res_valid  <= 1'b1;
                        res_data   <= prod_next[WIDTH-1:0];
                        res_flags  <= {1'b0, |prod_next[2*WIDTH-1:WIDTH],
                                       prod_next[WIDTH-1:0] == '0};
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
